// File: rtl/inertial_intf.sv
// Inertial sensor front end: power-up wait, one-time configuration writes, then a
// four-register burst read per data-ready interrupt, producing pitch rate and Z accel.
module inertial_intf #(
  parameter int INIT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  typedef enum logic [1:0] {
    PWR_WAIT,
    CFG,
    WAIT_INT,
    RD
  } state_t;

  state_t            state, nxt_state;
  logic [INIT_W-1:0] cnt;
  logic [1:0]        idx, nxt_idx;
  logic              int_ff1, int_ff2;
  logic              pend;
  logic              issue, acc;
  logic [7:0]        prl, prh, azl;

  // Only the low byte of the SPI response carries register data.
  logic unused_resp_hi;
  assign unused_resp_hi = ^resp[15:8];

  // Command table shared by the configuration and read sequences, selected by idx.
  function automatic logic [15:0] cmd_lut(input logic rd, input logic [1:0] i);
    logic [15:0] c;
    case (i)
      2'd0:    c = rd ? 16'hA200 : 16'h0D02;
      2'd1:    c = rd ? 16'hA300 : 16'h1053;
      2'd2:    c = rd ? 16'hAC00 : 16'h1150;
      default: c = rd ? 16'hAD00 : 16'h1460;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    nxt_state = state;
    nxt_idx   = idx;
    issue     = 1'b0;
    // A done only counts when it answers a wrt this FSM actually issued.
    acc       = done && pend && ((state == CFG) || (state == RD));
    case (state)
      PWR_WAIT: begin
        if (&cnt) begin
          nxt_state = CFG;
          issue     = 1'b1;
        end
      end
      CFG, RD: begin
        if (acc) begin
          nxt_idx = idx + 2'd1;
          if (idx == 2'd3) nxt_state = WAIT_INT;
          else             issue     = 1'b1;
        end
      end
      WAIT_INT: begin
        if (int_ff2) begin
          nxt_state = RD;
          issue     = 1'b1;
        end
      end
      default: nxt_state = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here, including the byte capture registers, is reset so a
    // mid-transaction reset leaves no stale data that could leak into ptch_rt/AZ.
    if (!rst_n) begin
      state   <= PWR_WAIT;
      cnt     <= '0;
      idx     <= 2'd0;
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
      pend    <= 1'b0;
      wrt     <= 1'b0;
      cmd     <= 16'h0000;
      vld     <= 1'b0;
      prl     <= 8'h00;
      prh     <= 8'h00;
      azl     <= 8'h00;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= nxt_state;
      idx     <= nxt_idx;
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
      wrt     <= issue;
      vld     <= 1'b0;
      if (state == PWR_WAIT) cnt <= cnt + {{(INIT_W-1){1'b0}}, 1'b1};
      if (issue) begin
        cmd  <= cmd_lut(nxt_state == RD, nxt_idx);
        pend <= 1'b1;
      end else if (acc) begin
        pend <= 1'b0;
      end
      // Outputs update only on the final byte, so a broken burst never disturbs them.
      if (acc && (state == RD)) begin
        case (idx)
          2'd0: prl <= resp[7:0];
          2'd1: prh <= resp[7:0];
          2'd2: azl <= resp[7:0];
          default: begin
            ptch_rt <= {prh, prl};
            AZ      <= {resp[7:0], azl};
            vld     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inertial_intf.sv
// Scoreboard bench for inertial_intf: an SPI sensor model answers commands from a
// register map, expected commands/results are queued by the stimulus, a monitor compares.
module tb_inertial_intf;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT   = 1'b0;
  logic        done  = 1'b0;
  logic [15:0] resp  = 16'h0000;
  logic        wrt, vld;
  logic [15:0] cmd, ptch_rt, AZ;

  inertial_intf #(.INIT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .done    (done),
    .resp    (resp),
    .wrt     (wrt),
    .cmd     (cmd),
    .ptch_rt (ptch_rt),
    .AZ      (AZ),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] a;
  } out_t;

  logic [15:0] exp_cmd_q[$];
  out_t        exp_out_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [7:0]  sens [0:127];
  int          fixed_dly = 0;
  bit          stray_req = 1'b0;
  bit          busy      = 1'b0;
  int          cd        = 0;
  logic [15:0] cur_cmd   = 16'h0000;
  bit          done_azh  = 1'b0;
  bit          rst_s     = 1'b0;
  bit          azh_s     = 1'b0;
  logic [15:0] held_p    = 16'h0000;
  logic [15:0] held_a    = 16'h0000;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sensor / SPI slave model: reads return the register map, writes are acknowledged.
  initial forever begin
    @(negedge clk);
    done     = 1'b0;
    done_azh = 1'b0;
    if (wrt) begin
      check(!busy, "one_outstanding", {31'd0, busy}, 32'd0);
      busy    = 1'b1;
      cur_cmd = cmd;
      cd      = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 6));
    end else if (busy) begin
      cd--;
      if (cd == 0) begin
        busy       = 1'b0;
        done       = 1'b1;
        resp[15:8] = 8'($urandom);
        resp[7:0]  = cur_cmd[15] ? sens[cur_cmd[14:8]] : 8'($urandom);
        done_azh   = (cur_cmd == 16'hAD00);
      end
    end else if (stray_req) begin
      done      = 1'b1;
      resp      = 16'($urandom);
      stray_req = 1'b0;
    end
  end

  always @(posedge clk) begin
    rst_s <= rst_n;
    azh_s <= done_azh;
  end

  // Monitor: pops the scoreboard whenever the DUT presents wrt or vld.
  initial forever begin
    logic [15:0] ec;
    out_t        eo;
    @(negedge clk);
    if (!rst_s) begin
      held_p = 16'h0000;
      held_a = 16'h0000;
      check(!wrt && !vld && cmd == 16'h0000 && ptch_rt == 16'h0000 && AZ == 16'h0000,
            "reset_outputs", {ptch_rt, AZ}, 32'd0);
    end else begin
      if (wrt) begin
        if (exp_cmd_q.size() == 0) begin
          check(1'b0, "unexpected_wrt", {16'd0, cmd}, 32'd0);
        end else begin
          ec = exp_cmd_q.pop_front();
          check(cmd == ec, "cmd", {16'd0, cmd}, {16'd0, ec});
        end
      end
      if (vld || azh_s) check(vld == azh_s, "vld_timing", {31'd0, vld}, {31'd0, azh_s});
      if (vld) begin
        if (exp_out_q.size() == 0) begin
          check(1'b0, "unexpected_vld", {ptch_rt, AZ}, 32'd0);
        end else begin
          eo = exp_out_q.pop_front();
          check(ptch_rt == eo.p, "ptch_rt", {16'd0, ptch_rt}, {16'd0, eo.p});
          check(AZ == eo.a, "AZ", {16'd0, AZ}, {16'd0, eo.a});
          held_p = eo.p;
          held_a = eo.a;
        end
      end else begin
        check(ptch_rt == held_p && AZ == held_a, "hold", {ptch_rt, AZ}, {held_p, held_a});
      end
    end
  end

  task automatic push_cfg();
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1053);
    exp_cmd_q.push_back(16'h1150);
    exp_cmd_q.push_back(16'h1460);
  endtask

  task automatic push_reads();
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    exp_cmd_q.push_back(16'hAD00);
  endtask

  task automatic set_sens(input logic [7:0] prl, input logic [7:0] prh,
                          input logic [7:0] azl, input logic [7:0] azh);
    sens[7'h22] = prl;
    sens[7'h23] = prh;
    sens[7'h2C] = azl;
    sens[7'h2D] = azh;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((exp_cmd_q.size() != 0 || exp_out_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(n < max, "idle_timeout", n, max);
  endtask

  // Count clocks from release of reset to the first configuration write.
  task automatic power_up();
    int n = 0;
    fixed_dly = 20;
    rst_n     = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!wrt && n < 100);
    check(n == 16, "pwr_wait_len", n, 16);
    wait_idle(400);
    repeat (10) @(negedge clk);
    fixed_dly = 0;
  endtask

  // Raise INT and measure the latency to the first read command.
  task automatic raise_int(input bit drop);
    int n = 0;
    INT = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!wrt && n < 50);
    if (drop) INT = 1'b0;
    check(n == 3, "int_latency", n, 3);
  endtask

  task automatic run_seq(input logic [7:0] prl, input logic [7:0] prh,
                         input logic [7:0] azl, input logic [7:0] azh);
    set_sens(prl, prh, azl, azh);
    push_reads();
    exp_out_q.push_back({{prh, prl}, {azh, azl}});
    raise_int(1'b1);
    wait_idle(300);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int vc;
    for (int i = 0; i < 128; i++) sens[i] = 8'h00;
    repeat (3) @(negedge clk);
    push_cfg();
    power_up();

    run_seq(8'h34, 8'h12, 8'hCD, 8'hAB);
    run_seq(8'hFF, 8'hFF, 8'h60, 8'hFF);

    // Stray done pulses and a sub-cycle INT glitch while idle.
    repeat (3) begin
      stray_req = 1'b1;
      repeat (5) @(negedge clk);
    end
    @(negedge clk);
    #2 INT = 1'b1;
    #2 INT = 1'b0;
    repeat (20) @(negedge clk);

    repeat (6) run_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    // Reset for one clock right after the second read completes.
    set_sens(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    push_reads();
    raise_int(1'b1);
    n = 0;
    while (!(wrt && cmd == 16'hAC00) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(n < 200, "third_read_timeout", n, 200);
    rst_n = 1'b0;
    @(negedge clk);
    exp_cmd_q.delete();
    exp_out_q.delete();
    push_cfg();
    power_up();
    run_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    // INT held high: three back-to-back bursts, each new burst one clock after vld.
    set_sens(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (3) begin
      push_reads();
      exp_out_q.push_back({{sens[7'h23], sens[7'h22]}, {sens[7'h2D], sens[7'h2C]}});
    end
    raise_int(1'b0);
    vc = 0;
    n  = 0;
    while (vc < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (vld) begin
        vc++;
        if (vc == 2) INT = 1'b0;
        if (vc < 3) begin
          @(negedge clk);
          check(wrt, "b2b_gap", {31'd0, wrt}, 32'd1);
        end
      end
    end
    INT = 1'b0;
    check(vc == 3, "b2b_count", vc, 3);
    wait_idle(300);
    repeat (20) @(negedge clk);

    check(exp_cmd_q.size() == 0 && exp_out_q.size() == 0, "scoreboard_empty",
          exp_cmd_q.size() + exp_out_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
